mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the MIPS pipeline's instruction-fetch (I) and memory-stage (D) requesters.
- Arbitrates between them, sequences each memory transaction, and returns per-requester stall, read data and completion pulses.
- Sits between the pipeline stage registers and the external memory model.
- Includes bounded D-priority fairness and an ack watchdog.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the fetch (I)
// and memory-stage (D) requesters, with bounded D priority and an ack watchdog.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int TIMEOUT      = 15,
  parameter int MAX_D_STREAK = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  input  logic          err_clr,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [7:0]    WDOG_LAST  = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_owner;        // 0 = I, 1 = D
  logic [SW-1:0] r_streak;
  logic [7:0]    r_wdog;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_err;

  logic w_any_req;
  logic w_grant_d;
  logic w_wdog_expired;
  logic w_timeout;

  // D wins a tie unless it has already taken MAX_D_STREAK grants past a waiting I.
  assign w_any_req      = i_req | d_req;
  assign w_grant_d      = d_req & (~i_req | (r_streak != STREAK_MAX));
  assign w_wdog_expired = (r_wdog == WDOG_LAST);
  assign w_timeout      = (r_state == S_BUSY) & w_wdog_expired & ~mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_BUSY;
      S_BUSY:  if (mem_ack || w_wdog_expired) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (r_state)
      S_BUSY: begin
        mem_req = 1'b1;
        mem_we  = r_mem_we;
      end
      S_DONE: begin
        i_done = ~r_owner;
        d_done = r_owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= 1'b0;
      r_streak    <= '0;
      r_wdog      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_grant_d;
            r_mem_addr <= w_grant_d ? d_addr : i_addr;
            r_mem_we   <= w_grant_d & d_we;
            if (w_grant_d) r_mem_wdata <= d_wdata;
            if (w_grant_d && i_req) begin
              if (r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
            end else begin
              r_streak <= '0;
            end
          end
        end
        S_BUSY: begin
          // An ack in the final watchdog cycle still delivers its data.
          if (mem_ack) begin
            r_wdog <= '0;
            if (!r_mem_we) begin
              if (r_owner) r_d_rdata <= mem_rdata;
              else         r_i_rdata <= mem_rdata;
            end
          end else if (w_wdog_expired) begin
            r_wdog <= '0;
            if (!r_mem_we) begin
              if (r_owner) r_d_rdata <= '0;
              else         r_i_rdata <= '0;
            end
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign i_stall     = i_req & ~i_done;
  assign d_stall     = d_req & ~d_done;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: every scenario task drives its own vectors
// and compares against hand-computed values.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_done, i_stall;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done, d_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          err;
  logic          err_clr = 1'b0;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15), .MAX_D_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .err_clr(err_clr), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
    n_cmp++; if ({i_done, d_done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {i_done, d_done, err}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_busy();
    i_req = 1'b1; i_addr = 16'h0010;
    step();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmb_busy1 got %b exp 1", mem_req); end
    step();
    n_cmp++; if (mem_addr !== 16'h0010) begin n_bad++; $display("FAIL rmb_addr got %h exp 0010", mem_addr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmb_mem_req got %b exp 0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL rmb_mem_addr got %h exp 0000", mem_addr); end
    n_cmp++; if ({mem_we, i_done, d_done, err} !== 4'b0000) begin n_bad++; $display("FAIL rmb_flags got %b exp 0000", {mem_we, i_done, d_done, err}); end
    n_cmp++; if ({i_rdata, d_rdata, mem_wdata} !== 48'h0) begin n_bad++; $display("FAIL rmb_data got %h exp 0", {i_rdata, d_rdata, mem_wdata}); end
    i_req = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if ({i_done, mem_req} !== 2'b00) begin n_bad++; $display("FAIL rmb_after_release c%0d got %b exp 00", k, {i_done, mem_req}); end
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 16'h0004;
    #1;
    n_cmp++; if (i_stall !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_c0 got %b exp 1", i_stall); end
    step();
    n_cmp++; if ({mem_req, mem_we, i_stall} !== 3'b101) begin n_bad++; $display("FAIL fetch_c1 got %b exp 101", {mem_req, mem_we, i_stall}); end
    n_cmp++; if (mem_addr !== 16'h0004) begin n_bad++; $display("FAIL fetch_addr got %h exp 0004", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h8C21;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    n_cmp++; if ({mem_req, i_done, i_stall, d_done} !== 4'b0100) begin n_bad++; $display("FAIL fetch_c2 got %b exp 0100", {mem_req, i_done, i_stall, d_done}); end
    n_cmp++; if (i_rdata !== 16'h8C21) begin n_bad++; $display("FAIL fetch_rdata got %h exp 8c21", i_rdata); end
    i_req = 1'b0;
    step();
    n_cmp++; if ({i_done, i_rdata} !== {1'b0, 16'h8C21}) begin n_bad++; $display("FAIL fetch_hold got %h exp 08c21", {i_done, i_rdata}); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h00AB;
    step();
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if ({mem_req, mem_we, d_stall} !== 3'b111) begin n_bad++; $display("FAIL store_c%0d_ctl got %b exp 111", k, {mem_req, mem_we, d_stall}); end
      n_cmp++; if ({mem_addr, mem_wdata} !== {16'h0040, 16'h00AB}) begin n_bad++; $display("FAIL store_c%0d_bus got %h exp 004000ab", k, {mem_addr, mem_wdata}); end
      if (k == 3) begin mem_ack = 1'b1; mem_rdata = 16'hFFFF; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    n_cmp++; if ({d_done, d_stall, mem_req, mem_we} !== 4'b1000) begin n_bad++; $display("FAIL store_c4 got %b exp 1000", {d_done, d_stall, mem_req, mem_we}); end
    n_cmp++; if (d_rdata !== 16'h0000) begin n_bad++; $display("FAIL store_rdata got %h exp 0000", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int run, max_run;
    logic exp_d;
    run = 0; max_run = 0;
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_addr = 16'h0300; d_we = 1'b0;
    #1;
    for (int t = 0; t < 8; t++) begin
      exp_d = ((t % 4) != 3);
      for (int ph = 0; ph < 3; ph++) begin
        run = i_stall ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (ph == 1) begin
          n_cmp++; if ({mem_req, mem_addr} !== {1'b1, exp_d ? 16'h0300 : 16'h0200}) begin n_bad++; $display("FAIL fair_t%0d_addr got %h exp %h", t, {mem_req, mem_addr}, {1'b1, exp_d ? 16'h0300 : 16'h0200}); end
          mem_ack = 1'b1; mem_rdata = 16'h0100 + 16'(t);
        end
        if (ph == 2) begin
          n_cmp++; if ({d_done, i_done} !== {exp_d, ~exp_d}) begin n_bad++; $display("FAIL fair_t%0d_grant got %b exp %b", t, {d_done, i_done}, {exp_d, ~exp_d}); end
          n_cmp++; if ((exp_d ? d_rdata : i_rdata) !== 16'h0100 + 16'(t)) begin n_bad++; $display("FAIL fair_t%0d_rdata got %h exp %h", t, exp_d ? d_rdata : i_rdata, 16'h0100 + 16'(t)); end
        end
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_cmp++; if (max_run !== 11) begin n_bad++; $display("FAIL fair_max_i_stall got %0d exp 11", max_run); end
    step();
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    step();
    for (int k = 1; k < 15; k++) begin
      n_cmp++; if ({mem_req, d_done} !== 2'b10) begin n_bad++; $display("FAIL tmo_c%0d got %b exp 10", k, {mem_req, d_done}); end
      step();
    end
    n_cmp++; if ({mem_req, err} !== 2'b10) begin n_bad++; $display("FAIL tmo_c15 got %b exp 10", {mem_req, err}); end
    step();
    n_cmp++; if ({d_done, err, d_rdata} !== {2'b11, 16'h0000}) begin n_bad++; $display("FAIL tmo_done got %h exp 30000", {d_done, err, d_rdata}); end
    d_req = 1'b0;
    step(); step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err_sticky got %b exp 1", err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clr got %b exp 0", err); end
    d_req = 1'b1; d_addr = 16'h0052;
    step();
    for (int k = 1; k < 15; k++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; d_req = 1'b0;
    n_cmp++; if ({d_done, err} !== 2'b11) begin n_bad++; $display("FAIL tmo_set_beats_clr got %b exp 11", {d_done, err}); end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_final_clr got %b exp 0", err); end
  endtask

  task automatic test_ack_boundary();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    step();
    for (int k = 1; k < 15; k++) step();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL bnd_c15 got %b exp 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000; d_req = 1'b0;
    n_cmp++; if ({d_done, err, d_rdata} !== {2'b10, 16'h1234}) begin n_bad++; $display("FAIL bnd_done got %h exp 21234", {d_done, err, d_rdata}); end
    step();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bnd_err got %b exp 0", err); end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step(); step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    n_cmp++; if ({mem_req, i_done, d_done, d_rdata, i_rdata} !== {3'b000, 16'h1234, 16'h0107}) begin n_bad++; $display("FAIL stray_ack got %h exp %h", {mem_req, i_done, d_done, d_rdata, i_rdata}, {3'b000, 16'h1234, 16'h0107}); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_single_fetch();
    test_store();
    test_fairness();
    test_timeout();
    test_ack_boundary();
    test_stray_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
